// File: rtl/pipelined_carry_skip_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_skip_adder
//
// Pipelined adder/subtractor for wide datapaths. The operand word is cut into
// STAGES equal segments; segment k is summed in pipeline stage k by a chain of
// carry-skip blocks, and the carry between segments is registered. Each token
// carries its unprocessed upper A bits, the conditioned B operand and the
// finished lower result bits, so the final word leaves the last stage aligned.
// A single global advance enable gives one operation per cycle with full
// valid/ready backpressure.
//
// Parameters:
//   DATA_WIDTH  - operand/result width in bits
//   BLOCK_WIDTH - bits per carry-skip block
//   STAGES      - pipeline segments == latency in cycles
//                 (DATA_WIDTH must be a multiple of BLOCK_WIDTH*STAGES)
//
// Ports:
//   clk_i        in   clock
//   rst_n_i      in   asynchronous active-low reset
//   operand_A_i  in   first operand
//   operand_B_i  in   second operand
//   carry_i      in   carry-in (add) / borrow-in (subtract)
//   subtract_i   in   0: A+B+carry_i   1: A-B-carry_i
//   valid_i      in   input operation valid
//   ready_o      out  adder accepts input this cycle (combinational from ready_i)
//   result_o     out  registered result, modulo 2^DATA_WIDTH
//   carry_o      out  raw carry out of the MSB (subtract: 1 = no borrow)
//   valid_o      out  result_o/carry_o valid
//   ready_i      in   downstream accepts the result
//   overflow_o   out  signed overflow, aligned with result_o
//                     (present only when OVERFLOW_FLAG_EN is defined)
//
// Build option: define OVERFLOW_FLAG_EN to add the overflow_o output.
// -----------------------------------------------------------------------------
module pipelined_carry_skip_adder #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 4,
    parameter int STAGES      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic                  carry_i,
    input  logic                  subtract_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic                  valid_o,
    input  logic                  ready_i
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                  overflow_o
`endif
);

    localparam int SEG  = DATA_WIDTH / STAGES;   // bits handled per stage
    localparam int NBLK = SEG / BLOCK_WIDTH;     // carry-skip blocks per stage

    if (STAGES < 1 || BLOCK_WIDTH < 1 ||
        (DATA_WIDTH % (BLOCK_WIDTH * STAGES)) != 0) begin : g_bad_params
        $error("pipelined_carry_skip_adder: DATA_WIDTH must be a multiple of BLOCK_WIDTH*STAGES");
    end

    // One in-flight operation. 'word' holds finished result bits below the
    // current segment and untouched A bits above it; 'carry' is the carry
    // into the next segment (after the last stage: the MSB carry-out).
    typedef struct packed {
        logic                  valid;
        logic                  carry;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] word;
    } token_t;

    // -------------------------------------------------------------------------
    // Carry-skip segment adder: returns {carry_out, sum}.
    // A block whose bits all propagate forwards its own carry-in directly, so
    // a long propagate run costs one mux per block rather than a full ripple.
    // -------------------------------------------------------------------------
    function automatic logic [SEG:0] csk_segment(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic [SEG-1:0] sum;
        logic           carry;
        logic           blk_cin;
        logic           blk_prop;
        logic           p;
        // NOTE: blocking assignments here model the ripple inside a block;
        // each bit must see the carry just produced by the bit below it.
        sum   = '0;
        carry = cin;
        for (int blk = 0; blk < NBLK; blk++) begin
            blk_cin  = carry;
            blk_prop = 1'b1;
            for (int i = 0; i < BLOCK_WIDTH; i++) begin
                p                         = a[blk*BLOCK_WIDTH + i] ^ b[blk*BLOCK_WIDTH + i];
                sum[blk*BLOCK_WIDTH + i]  = p ^ carry;
                carry                     = (a[blk*BLOCK_WIDTH + i] & b[blk*BLOCK_WIDTH + i]) | (p & carry);
                blk_prop                  = blk_prop & p;
            end
            if (blk_prop) begin
                carry = blk_cin;          // skip path
            end
        end
        return {carry, sum};
    endfunction

    // -------------------------------------------------------------------------
    // Operand conditioning: subtraction is A + ~B + ~borrow.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] b_cond;
    logic                  cin_cond;

    assign b_cond   = subtract_i ? ~operand_B_i : operand_B_i;
    assign cin_cond = subtract_i ? ~carry_i     : carry_i;

    // -------------------------------------------------------------------------
    // Pipeline
    // -------------------------------------------------------------------------
    token_t         pipe_q   [STAGES];
    token_t         pipe_d   [STAGES];
    token_t         stage_in [STAGES];
    logic [SEG:0]   seg_res  [STAGES];
    logic           en;

    // The whole pipe moves together; it only stalls when the output holds a
    // valid result the consumer is not taking.
    assign en      = ready_i | ~pipe_q[STAGES-1].valid;
    assign ready_o = en;

    always_comb begin
        // NOTE: every element is assigned on every pass through this block,
        // so no latch can be inferred for stage_in, seg_res or pipe_d.
        stage_in[0] = '{valid: valid_i, carry: cin_cond, b: b_cond, word: operand_A_i};
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = pipe_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_res[k] = csk_segment(stage_in[k].word[k*SEG +: SEG],
                                     stage_in[k].b[k*SEG +: SEG],
                                     stage_in[k].carry);
            pipe_d[k]                     = stage_in[k];
            pipe_d[k].word[k*SEG +: SEG]  = seg_res[k][SEG-1:0];
            pipe_d[k].carry               = seg_res[k][SEG];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: data registers are cleared along with the valid bits so
            // result_o/carry_o read 0 out of reset instead of stale data.
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (en) begin
            // NOTE: non-blocking so every stage samples its predecessor's
            // pre-edge value and tokens move exactly one stage per clock.
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign result_o = pipe_q[STAGES-1].word;
    assign carry_o  = pipe_q[STAGES-1].carry;
    assign valid_o  = pipe_q[STAGES-1].valid;

`ifdef OVERFLOW_FLAG_EN
    // -------------------------------------------------------------------------
    // Signed overflow = carry into MSB ^ carry out of MSB. The carry into the
    // MSB is recovered from the MSB sum bit: c_in = a ^ b ^ s.
    // -------------------------------------------------------------------------
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = seg_res[STAGES-1][SEG]
                 ^ stage_in[STAGES-1].word[DATA_WIDTH-1]
                 ^ stage_in[STAGES-1].b[DATA_WIDTH-1]
                 ^ seg_res[STAGES-1][SEG-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// -----------------------------------------------------------------------------
// Testbench for pipelined_carry_skip_adder (DATA_WIDTH=32, BLOCK_WIDTH=4,
// STAGES=2). A driver pushes the expected response of every accepted
// operation into a queue; a monitor pops and compares whenever the adder
// hands over a result. Expected values come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_pipelined_carry_skip_adder;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int ST = 2;

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [DW-1:0] operand_A_i = '0;
    logic [DW-1:0] operand_B_i = '0;
    logic          carry_i = 1'b0;
    logic          subtract_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] result_o;
    logic          carry_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
`ifdef OVERFLOW_FLAG_EN
    logic          overflow_o;
`endif

    always #5 clk = ~clk;

    pipelined_carry_skip_adder #(
        .DATA_WIDTH (DW),
        .BLOCK_WIDTH(BW),
        .STAGES     (ST)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .operand_A_i(operand_A_i),
        .operand_B_i(operand_B_i),
        .carry_i    (carry_i),
        .subtract_i (subtract_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .carry_o    (carry_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
`ifdef OVERFLOW_FLAG_EN
        ,
        .overflow_o (overflow_o)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] res;
        logic          carry;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   n_checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on wide integers.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic c, input logic sub);
        exp_t              e;
        longint unsigned   ua;
        longint unsigned   ub;
        longint unsigned   uc;
        longint unsigned   sum;
        longint            sa;
        longint            sb;
        longint            sv;
        ua = 64'(a);
        ub = 64'(b);
        uc = 64'(c);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!sub) begin
            sum     = ua + ub + uc;
            e.res   = sum[DW-1:0];
            e.carry = sum[DW];
            sv      = sa + sb + longint'(uc);
        end else begin
            sum     = ua - ub - uc;
            e.res   = sum[DW-1:0];
            e.carry = (ua >= ub + uc);         // 1 = no borrow
            sv      = sa - sb - longint'(uc);
        end
        e.ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_op();
        logic [DW-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h7FFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h0000_FFFF;
            5:       v = 32'hFFFF_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // One cycle of stimulus: drive after the falling edge, then record the
    // expected response if the operation will be taken at the next rising edge.
    task automatic step(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic c, input logic sub, input logic rdy, output logic acc);
        @(negedge clk);
        valid_i     = v;
        operand_A_i = a;
        operand_B_i = b;
        carry_i     = c;
        subtract_i  = sub;
        ready_i     = rdy;
        #1;
        acc = v && ready_o;
        if (acc) begin
            exp_q.push_back(model(a, b, c, sub));
            n_vec++;
        end
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        step(1'b0, '0, '0, 1'b0, 1'b0, rdy, acc);
    endtask

    task automatic latency_test(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic c, input logic sub);
        logic acc;
        int   lat;
        lat = -1;
        step(1'b1, a, b, c, sub, 1'b1, acc);
        check("latency_accept", 64'(acc), 64'(1));
        for (int n = 1; n <= 10; n++) begin
            idle(1'b1);
            if (valid_o) begin
                lat = n;
                break;
            end
        end
        check("latency_cycles", 64'(lat), 64'(ST));
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
            idle(1'b1);
        end
        check("drain_outstanding", 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: one comparison per completed output handshake.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL spurious_output: got result 0x%h, expected no output", result_o);
            end else begin
                e = exp_q.pop_front();
                check("result_carry", 64'({carry_o, result_o}), 64'({e.carry, e.res}));
`ifdef OVERFLOW_FLAG_EN
                check("overflow", 64'(overflow_o), 64'(e.ovf));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          acc;
        logic          v;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          c;
        logic          s;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid_o",  64'(valid_o),  64'(0));
        check("reset_result_o", 64'(result_o), 64'(0));
        check("reset_carry_o",  64'(carry_o),  64'(0));
        check("reset_ready_o",  64'(ready_o),  64'(1));
`ifdef OVERFLOW_FLAG_EN
        check("reset_overflow_o", 64'(overflow_o), 64'(0));
`endif
        @(negedge clk);
        rst_n_i = 1'b1;

        // Directed corner cases, each with a latency measurement
        latency_test(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);   // full skip chain
        latency_test(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);   // segment-boundary carry
        latency_test(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);   // borrow out
        latency_test(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);   // borrow in, no borrow out
        latency_test(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);   // signed overflow
        drain();

        // Backpressure: 1+1, 2+2 in flight, stall two cycles, then 3+3
        step(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1, acc);
        for (int n = 0; n < 2; n++) begin
            step(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, acc);
            check("stall_valid_o", 64'(valid_o),  64'(1));
            check("stall_ready_o", 64'(ready_o),  64'(0));
            check("stall_result",  64'(result_o), 64'(2));
            check("stall_no_accept", 64'(acc), 64'(0));
        end
        step(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1, acc);
        check("release_accept", 64'(acc), 64'(1));
        drain();

        // Randomized traffic with random backpressure; a refused operation
        // is held until it is taken.
        acc = 1'b1;
        v = 1'b0; a = '0; b = '0; c = 1'b0; s = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (acc || !v) begin
                v = ($urandom_range(0, 9) < 7);
                a = rand_op();
                b = rand_op();
                c = 1'($urandom_range(0, 1));
                s = 1'($urandom_range(0, 1));
            end
            step(v, a, b, c, s, ($urandom_range(0, 9) < 7), acc);
        end
        drain();

        // Reset with two tokens in flight
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b1, acc);
        idle(1'b0);
        check("pre_reset_valid_o", 64'(valid_o), 64'(1));
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midreset_valid_o",  64'(valid_o),  64'(0));
        check("midreset_result_o", 64'(result_o), 64'(0));
        check("midreset_carry_o",  64'(carry_o),  64'(0));
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
        for (int n = 0; n < 5; n++) begin
            idle(1'b1);
            check("post_reset_valid_o", 64'(valid_o), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
